adc_moving_averager: RTL

- Boxcar (moving-average) filter over the last N raw ADC samples. Produces the *_ave words that the menu subsystem's averaging mux selects.
- One instance per converter path (XADC, PWM ramp, R2R). Each instance sits directly upstream of the menu subsystem's averaging mux.
- Input is the converter's raw sample word plus a one-cycle valid strobe.
- Output is a registered 16-bit average plus a one-cycle valid strobe.

---
 rtl/adc_avg_pkg.sv | 6 +
 rtl/avg_sample_ram.sv | 19 +
 rtl/adc_moving_averager.sv | 61 ++++++
 3 files changed

// File: rtl/adc_avg_pkg.sv
// adc_avg_pkg: shared defaults and state type for the ADC moving averager
package adc_avg_pkg;
    localparam int AVG_DATA_W = 16;
    localparam int AVG_LOG2_N = 8;
    typedef enum logic {FILL, RUN} avg_state_t;
endpackage

// File: rtl/avg_sample_ram.sv
// avg_sample_ram: N x DATA_W sample window, one write port, async read at the same address
module avg_sample_ram
    import adc_avg_pkg::*;
#(
    parameter int DATA_W = AVG_DATA_W,
    parameter int ADDR_W = AVG_LOG2_N
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [2**ADDR_W];
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end
    assign rdata = mem[addr];
endmodule

// File: rtl/adc_moving_averager.sv
// adc_moving_averager: boxcar average of the last 2**LOG2_N raw converter samples
module adc_moving_averager
    import adc_avg_pkg::*;
#(
    parameter int DATA_W = AVG_DATA_W,
    parameter int LOG2_N = AVG_LOG2_N
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    output logic [DATA_W-1:0] ave_out,
    output logic              ave_valid,
    output logic              filled
);
    localparam int SUM_W = DATA_W + LOG2_N;
    localparam logic [LOG2_N:0] LAST = (LOG2_N + 1)'(2**LOG2_N - 1);
    avg_state_t        state;
    logic [LOG2_N-1:0] wr_ptr;
    logic [LOG2_N:0]   count;
    logic [SUM_W-1:0]  sum, sum_next;
    logic [DATA_W-1:0] rd_data, old_sample;
    logic              accept;
    assign accept = enable && sample_valid;
    // the buffer slot is only meaningful once the window has wrapped
    assign old_sample = (state == RUN) ? rd_data : '0;
    assign sum_next = sum + SUM_W'(sample_in) - SUM_W'(old_sample);
    avg_sample_ram #(.DATA_W(DATA_W), .ADDR_W(LOG2_N)) u_ram (
        .clk   (clk),
        .we    (accept && !reset),
        .addr  (wr_ptr),
        .wdata (sample_in),
        .rdata (rd_data)
    );
    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            state     <= FILL;
            sum       <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            ave_out   <= '0;
            ave_valid <= 1'b0;
            filled    <= 1'b0;
        end else begin
            ave_valid <= sample_valid;
            if (sample_valid) begin
                sum     <= sum_next;
                wr_ptr  <= wr_ptr + 1'b1;
                ave_out <= sum_next[SUM_W-1:LOG2_N];
                if (state == FILL) begin
                    count <= count + 1'b1;
                    if (count == LAST) begin
                        state  <= RUN;
                        filled <= 1'b1;
                    end
                end
            end
        end
    end
endmodule
